// File: rtl/reg_file_port_arbiter_pkg.sv
// Shared types for the register-file port arbiter: read-FSM states and pointer sizing.
// No logic; imported by the arbiter top and its round-robin sub-module.
package reg_file_port_arbiter_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_PEND = 1'b1
  } rd_state_e;

  // Pointer width; never narrower than one bit so NUM_REQ=2 still has a register.
  function automatic int ptr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_file_port_arbiter_rr_arbiter.sv
// Round-robin picker: combinational one-hot grant searching upward from ptr_q, 0 cycles.
// Pointer moves past the winner only on adv_i; a caller holding off the grant just clears req_i.
module rr_arbiter
  import reg_file_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int PW = ptr_w(NUM_REQ);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win;
  logic          found;
  int            idx;

  always_comb begin
    gnt_o = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win        = PW'(idx);
      end
    end
  end

  // Explicit wrap so non-power-of-two NUM_REQ never reaches an unused code.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) ptr_d = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/reg_file_port_arbiter.sv
// Shares a 1R/1W register file among NUM_REQ requesters: write grant is 0-cycle, read response is
// registered 1 cycle later with write-first bypass; a pending response blocks new reads until accepted.
module reg_file_port_arbiter
  import reg_file_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        wr_valid_in,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr_in,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data_in,
  output logic [NUM_REQ-1:0]        wr_ready_out,
  input  logic [NUM_REQ-1:0]        rd_valid_in,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr_in,
  output logic [NUM_REQ-1:0]        rd_ready_out,
  output logic [NUM_REQ-1:0]        rsp_valid_out,
  output logic [DATA_W-1:0]         rsp_data_out,
  input  logic [NUM_REQ-1:0]        rsp_ready_in,
  output logic                      rf_wen_out,
  output logic [ADDR_W-1:0]         rf_waddr_out,
  output logic [DATA_W-1:0]         rf_d_out,
  output logic [ADDR_W-1:0]         rf_raddr_out,
  input  logic [DATA_W-1:0]         rf_a_in
);

  rd_state_e            state_q, state_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]   wr_req, wr_gnt;
  logic [NUM_REQ-1:0]   rd_req, rd_gnt;
  logic                 rsp_acc, rd_open, rd_xfer;
  logic [DATA_W-1:0]    rdata;

  // Grants are suppressed while reset_n is low so no write can reach the file.
  assign wr_req = wr_valid_in & {NUM_REQ{reset_n}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req_i   (wr_req),
    .adv_i   (|wr_gnt),
    .gnt_o   (wr_gnt)
  );

  assign wr_ready_out = wr_gnt;
  assign rf_wen_out   = |(wr_valid_in & wr_gnt);

  always_comb begin
    rf_waddr_out = '0;
    rf_d_out     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) begin
        rf_waddr_out = wr_addr_in[i*ADDR_W +: ADDR_W];
        rf_d_out     = wr_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Reads open in IDLE, or in PEND on the cycle the held response is taken (back-to-back).
  assign rsp_acc = |(rsp_valid_q & rsp_ready_in);
  assign rd_open = (state_q == RD_IDLE) || rsp_acc;
  assign rd_req  = rd_valid_in & {NUM_REQ{reset_n & rd_open}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req_i   (rd_req),
    .adv_i   (|rd_gnt),
    .gnt_o   (rd_gnt)
  );

  assign rd_ready_out = rd_gnt;
  assign rd_xfer      = |(rd_valid_in & rd_gnt);

  always_comb begin
    rf_raddr_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_gnt[i]) rf_raddr_out = rd_addr_in[i*ADDR_W +: ADDR_W];
    end
  end

  assign rdata = (rf_wen_out && (rf_waddr_out == rf_raddr_out)) ? rf_d_out : rf_a_in;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      RD_IDLE: begin
        if (rd_xfer) begin
          rsp_valid_d = rd_gnt;
          rsp_data_d  = rdata;
          state_d     = RD_PEND;
        end
      end
      RD_PEND: begin
        if (rsp_acc) begin
          if (rd_xfer) begin
            rsp_valid_d = rd_gnt;
            rsp_data_d  = rdata;
          end else begin
            rsp_valid_d = '0;
            state_d     = RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RD_IDLE;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid_out = rsp_valid_q;
  assign rsp_data_out  = rsp_data_q;

endmodule

// File: tb/tb_reg_file_port_arbiter.sv
// Directed scenarios plus randomized traffic, every cycle compared against a transaction-level model.
module tb_reg_file_port_arbiter;

  localparam int N  = 2;
  localparam int DW = 16;
  localparam int AW = 1;

  logic            clock;
  logic            reset_n;
  logic [N-1:0]    wr_valid_in, wr_ready_out;
  logic [N*AW-1:0] wr_addr_in;
  logic [N*DW-1:0] wr_data_in;
  logic [N-1:0]    rd_valid_in, rd_ready_out;
  logic [N*AW-1:0] rd_addr_in;
  logic [N-1:0]    rsp_valid_out, rsp_ready_in;
  logic [DW-1:0]   rsp_data_out;
  logic            rf_wen_out;
  logic [AW-1:0]   rf_waddr_out, rf_raddr_out;
  logic [DW-1:0]   rf_d_out, rf_a_in;

  reg_file_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .wr_valid_in   (wr_valid_in),
    .wr_addr_in    (wr_addr_in),
    .wr_data_in    (wr_data_in),
    .wr_ready_out  (wr_ready_out),
    .rd_valid_in   (rd_valid_in),
    .rd_addr_in    (rd_addr_in),
    .rd_ready_out  (rd_ready_out),
    .rsp_valid_out (rsp_valid_out),
    .rsp_data_out  (rsp_data_out),
    .rsp_ready_in  (rsp_ready_in),
    .rf_wen_out    (rf_wen_out),
    .rf_waddr_out  (rf_waddr_out),
    .rf_d_out      (rf_d_out),
    .rf_raddr_out  (rf_raddr_out),
    .rf_a_in       (rf_a_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment register file driven only by the DUT pins.
  logic [DW-1:0] rf_mem [2];
  initial begin
    rf_mem[0] = '0;
    rf_mem[1] = '0;
  end
  always @(posedge clock) if (rf_wen_out) rf_mem[rf_waddr_out] <= rf_d_out;
  assign rf_a_in = rf_mem[rf_raddr_out];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: pointers, memory contents, owner of the pending response.
  int            m_wr_ptr, m_rd_ptr, m_own;
  logic [DW-1:0] m_rdat;
  logic [DW-1:0] m_mem [2];
  logic [N-1:0]  last_wg, last_rg;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Called at a negedge with inputs set; checks this cycle, advances the model, returns at next negedge.
  task automatic cycle();
    int            wg, rg;
    bit            acc;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, rdat;
    logic [N-1:0]  ew, er, ev;
    #1;
    if (!reset_n) begin
      m_own = -1; m_rdat = '0; m_wr_ptr = 0; m_rd_ptr = 0;
    end
    wg  = reset_n ? pick(wr_valid_in, m_wr_ptr) : -1;
    acc = (m_own >= 0) && rsp_ready_in[m_own];
    rg  = (reset_n && (m_own < 0 || acc)) ? pick(rd_valid_in, m_rd_ptr) : -1;
    ew = '0; er = '0; ev = '0;
    wa = '0; wd = '0; ra = '0;
    if (wg >= 0) begin
      ew[wg] = 1'b1; wa = wr_addr_in[wg*AW +: AW]; wd = wr_data_in[wg*DW +: DW];
    end
    if (rg >= 0) begin
      er[rg] = 1'b1; ra = rd_addr_in[rg*AW +: AW];
    end
    if (m_own >= 0) ev[m_own] = 1'b1;
    rdat = (wg >= 0 && wa == ra) ? wd : m_mem[ra];
    check_eq("wr_ready", 32'(wr_ready_out), 32'(ew));
    check_eq("rf_wen", 32'(rf_wen_out), 32'(wg >= 0));
    check_eq("rf_waddr", 32'(rf_waddr_out), 32'(wa));
    check_eq("rf_d", 32'(rf_d_out), 32'(wd));
    check_eq("rd_ready", 32'(rd_ready_out), 32'(er));
    check_eq("rf_raddr", 32'(rf_raddr_out), 32'(ra));
    check_eq("rsp_valid", 32'(rsp_valid_out), 32'(ev));
    if (m_own >= 0 || !reset_n) check_eq("rsp_data", 32'(rsp_data_out), 32'(m_rdat));
    @(posedge clock);
    if (reset_n) begin
      if (wg >= 0) begin
        m_mem[wa] = wd;
        m_wr_ptr  = (wg + 1) % N;
      end
      if (rg >= 0) begin
        m_own = rg; m_rdat = rdat; m_rd_ptr = (rg + 1) % N;
      end else if (acc) begin
        m_own = -1;
      end
    end
    last_wg = ew;
    last_rg = er;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; wr_valid_in = '0; rd_valid_in = '0; rsp_ready_in = '0;
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    m_wr_ptr = 0; m_rd_ptr = 0; m_own = -1; m_rdat = '0;
    m_mem[0] = '0; m_mem[1] = '0;
    last_wg = '0; last_rg = '0;
    reset_n = 1'b0; wr_valid_in = '1; rd_valid_in = '1; rsp_ready_in = '0;
    wr_addr_in = '0; wr_data_in = '0; rd_addr_in = '0;

    // Reset held with every valid high: nothing granted, nothing written.
    @(negedge clock);
    cycle();
    cycle();
    reset_n = 1'b1;
    #1;
    check_eq("rel_wgnt", 32'(wr_ready_out), 32'h1);
    check_eq("rel_rgnt", 32'(rd_ready_out), 32'h1);
    cycle();
    wr_valid_in = '0; rd_valid_in = '0; rsp_ready_in = '1;
    cycle();

    // Write-first bypass: req0 writes addr0 while req1 reads addr0.
    wr_valid_in = 2'b01; wr_addr_in = 2'b00; wr_data_in = {16'h0000, 16'h5A5A};
    rd_valid_in = 2'b10; rd_addr_in = 2'b00;
    cycle();
    wr_valid_in = '0; rd_valid_in = '0;
    #1;
    check_eq("byp_vld", 32'(rsp_valid_out), 32'h2);
    check_eq("byp_dat", 32'(rsp_data_out), 32'h5A5A);
    cycle();

    // Write round robin from a fresh pointer.
    do_reset();
    wr_valid_in = 2'b11; wr_addr_in = 2'b10; wr_data_in = {16'h2222, 16'h1111};
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("wrr_gnt", 32'(wr_ready_out), (c % 2 == 0) ? 32'h1 : 32'h2);
      cycle();
    end
    wr_valid_in = '0;
    check_eq("wrr_rf0", 32'(rf_mem[0]), 32'h1111);
    check_eq("wrr_rf1", 32'(rf_mem[1]), 32'h2222);

    // Read latency: write then read addr1 through req1.
    rsp_ready_in = '1;
    wr_valid_in = 2'b10; wr_addr_in = 2'b10; wr_data_in = {16'hABCD, 16'h0000};
    cycle();
    wr_valid_in = '0; rd_valid_in = 2'b10; rd_addr_in = 2'b10;
    cycle();
    rd_valid_in = '0;
    #1;
    check_eq("lat_vld", 32'(rsp_valid_out), 32'h2);
    check_eq("lat_dat", 32'(rsp_data_out), 32'hABCD);
    cycle();

    // Backpressure: response held three cycles, req1 granted in the accept cycle.
    do_reset();
    rd_valid_in = 2'b01; rd_addr_in = 2'b01; rsp_ready_in = '0;
    cycle();
    rd_valid_in = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("bp_rgnt", 32'(rd_ready_out), 32'h0);
      check_eq("bp_vld", 32'(rsp_valid_out), 32'h1);
      check_eq("bp_dat", 32'(rsp_data_out), 32'hABCD);
      cycle();
    end
    rsp_ready_in = 2'b01;
    #1;
    check_eq("bp_acc_gnt", 32'(rd_ready_out), 32'h2);
    cycle();
    rd_valid_in = '0; rsp_ready_in = '1;
    #1;
    check_eq("bp_next_vld", 32'(rsp_valid_out), 32'h2);
    cycle();

    // Reset while a response is pending.
    rd_valid_in = 2'b01; rsp_ready_in = '0;
    cycle();
    check_eq("mid_pend", 32'(rsp_valid_out), 32'h1);
    reset_n = 1'b0; rd_valid_in = '0;
    #1;
    check_eq("mid_rst_vld", 32'(rsp_valid_out), 32'h0);
    cycle();
    reset_n = 1'b1; rd_valid_in = 2'b11; rsp_ready_in = '1;
    #1;
    check_eq("mid_rel_gnt", 32'(rd_ready_out), 32'h1);
    cycle();

    // Randomized traffic; requesters hold a request until granted.
    for (int c = 0; c < 2000; c++) begin
      reset_n = ($urandom % 150) != 0;
      for (int i = 0; i < N; i++) begin
        if (!wr_valid_in[i] || last_wg[i]) begin
          wr_valid_in[i]           = ($urandom % 3) != 0;
          wr_addr_in[i]            = 1'($urandom % 2);
          wr_data_in[i*DW +: DW]   = 16'($urandom);
        end
        if (!rd_valid_in[i] || last_rg[i]) begin
          rd_valid_in[i] = ($urandom % 3) != 0;
          rd_addr_in[i]  = 1'($urandom % 2);
        end
        rsp_ready_in[i] = ($urandom % 2) != 0;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
